// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single-port memory with fixed read latency.
// Grants are combinational in IDLE, round-robin on ties; responses are registered one cycle after the data beat.
module mem_arbiter #(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  parameter  int MEM_LATENCY = 1,
  localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [BE_WIDTH-1:0]   ls_be,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [3:0] LAT     = 4'(MEM_LATENCY);

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  owner_ls_q, owner_ls_d;
  logic                  owner_we_q, owner_we_d;
  logic                  last_ls_q, last_ls_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  gnt_if, gnt_ls;

  // Grants are gated by rst_n so the combinational outputs drop the moment reset asserts.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      gnt_if = if_req && (!ls_req || last_ls_q);
      gnt_ls = ls_req && !gnt_if;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_if) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = if_addr;
    end else if (gnt_ls) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_ls_d  = owner_ls_q;
    owner_we_d  = owner_we_q;
    last_ls_d   = last_ls_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_if || gnt_ls) begin
          state_d    = ST_WAIT;
          cnt_d      = LAT;
          owner_ls_d = gnt_ls;
          owner_we_d = gnt_ls && ls_we;
          last_ls_d  = gnt_ls;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Count of 1 marks the cycle the memory presents its data.
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          if (owner_ls_q) begin
            ls_rvalid_d = 1'b1;
            if (!owner_we_q) ls_rdata_d = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      owner_ls_q  <= 1'b0;
      owner_we_q  <= 1'b0;
      last_ls_q   <= 1'b1;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_ls_q  <= owner_ls_d;
      owner_we_q  <= owner_we_d;
      last_ls_q   <= last_ls_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_gnt    = gnt_if;
  assign ls_gnt    = gnt_ls;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 and 3) share one stimulus stream and are
// checked every cycle against a transaction-level model, plus literal expectations.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [BW-1:0] ls_be;
  logic [DW-1:0] ls_wdata, mem_rdata;

  logic          if_gnt[2], if_rvalid[2], ls_gnt[2], ls_rvalid[2], mem_en[2], mem_we[2];
  logic [DW-1:0] if_rdata[2], ls_rdata[2], mem_wdata[2];
  logic [BW-1:0] mem_be[2];
  logic [AW-1:0] mem_addr[2];

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access per instance, completion at grant+lat+1.
  int            cyc = 0;
  int            lat[2] = '{1, 3};
  bit            busy[2], own_ls[2], own_we[2], last_ls[2];
  int            cap_c[2], done_c[2];
  logic [DW-1:0] cap_v[2], e_ifd[2], e_lsd[2];

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      bit gi, gl, rvi, rvl, en, we;
      logic [BW-1:0] be;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      gi = 0; gl = 0; rvi = 0; rvl = 0; en = 0; we = 0; be = '0; a = '0; wd = '0;
      if (!rst_n) begin
        busy[k] = 0; last_ls[k] = 1; e_ifd[k] = '0; e_lsd[k] = '0;
      end else begin
        if (busy[k] && cyc == cap_c[k]) cap_v[k] = mem_rdata;
        if (busy[k] && cyc == done_c[k]) begin
          busy[k] = 0;
          if (own_ls[k]) begin
            rvl = 1;
            if (!own_we[k]) e_lsd[k] = cap_v[k];
          end else begin
            rvi = 1;
            e_ifd[k] = cap_v[k];
          end
        end
        if (!busy[k]) begin
          gi = if_req && (!ls_req || last_ls[k]);
          gl = ls_req && !gi;
          if (gi) begin en = 1; be = '1; a = if_addr; end
          if (gl) begin en = 1; we = ls_we; be = ls_be; a = ls_addr; wd = ls_wdata; end
          if (gi || gl) begin
            busy[k]    = 1;
            own_ls[k]  = gl;
            own_we[k]  = gl && ls_we;
            cap_c[k]   = cyc + lat[k];
            done_c[k]  = cyc + lat[k] + 1;
            last_ls[k] = gl;
          end
        end
      end
      chk($sformatf("L%0d if_gnt", lat[k]),    64'(if_gnt[k]),    64'(gi));
      chk($sformatf("L%0d ls_gnt", lat[k]),    64'(ls_gnt[k]),    64'(gl));
      chk($sformatf("L%0d if_rvalid", lat[k]), 64'(if_rvalid[k]), 64'(rvi));
      chk($sformatf("L%0d ls_rvalid", lat[k]), 64'(ls_rvalid[k]), 64'(rvl));
      chk($sformatf("L%0d if_rdata", lat[k]),  64'(if_rdata[k]),  64'(e_ifd[k]));
      chk($sformatf("L%0d ls_rdata", lat[k]),  64'(ls_rdata[k]),  64'(e_lsd[k]));
      chk($sformatf("L%0d mem_en", lat[k]),    64'(mem_en[k]),    64'(en));
      chk($sformatf("L%0d mem_we", lat[k]),    64'(mem_we[k]),    64'(we));
      chk($sformatf("L%0d mem_be", lat[k]),    64'(mem_be[k]),    64'(be));
      chk($sformatf("L%0d mem_addr", lat[k]),  64'(mem_addr[k]),  64'(a));
      chk($sformatf("L%0d mem_wdata", lat[k]), 64'(mem_wdata[k]), 64'(wd));
    end
    cyc++;
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic idle_in();
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    mem_rdata = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      idle_in(); settle(); adv();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    adv();
    // Reset with requests pending: grants must stay low.
    for (int i = 0; i < 2; i++) begin
      idle_in(); if_req = 1; ls_req = 1; settle();
      chk("rst if_gnt", 64'(if_gnt[0]), 64'd0);
      chk("rst ls_gnt", 64'(ls_gnt[1]), 64'd0);
      chk("rst mem_en", 64'(mem_en[0]), 64'd0);
      adv();
    end

    // Single fetch, latency 1: grant at T, data at T+1, response at T+2.
    rst_n = 1'b1;
    idle_in(); if_req = 1; if_addr = 32'h100; settle();
    chk("fetch if_gnt T", 64'(if_gnt[0]), 64'd1);
    chk("fetch mem_addr T", 64'(mem_addr[0]), 64'h100);
    chk("fetch mem_be T", 64'(mem_be[0]), 64'hF);
    adv();
    idle_in(); mem_rdata = 32'h00500093; settle();
    chk("fetch if_gnt T+1", 64'(if_gnt[0]), 64'd0);
    adv();
    idle_in(); settle();
    chk("fetch if_rvalid T+2", 64'(if_rvalid[0]), 64'd1);
    chk("fetch if_rdata T+2", 64'(if_rdata[0]), 64'h00500093);
    adv();
    idle_cycles(4);

    // Store: write enables and byte lanes forwarded, ls_rdata untouched.
    idle_in(); ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF; settle();
    chk("store mem_we", 64'(mem_we[0]), 64'd1);
    chk("store mem_be", 64'(mem_be[0]), 64'h3);
    chk("store mem_wdata", 64'(mem_wdata[0]), 64'hDEADBEEF);
    adv();
    idle_cycles(1);
    idle_in(); settle();
    chk("store ls_rvalid T+2", 64'(ls_rvalid[0]), 64'd1);
    chk("store ls_rdata kept", 64'(ls_rdata[0]), 64'd0);
    adv();
    idle_cycles(4);

    // Both requesting from reset: fetch first, then alternate.
    rst_n = 1'b0; idle_cycles(2); rst_n = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      idle_in(); if_req = 1; if_addr = 32'h40 + 32'(i); ls_req = 1; ls_addr = 32'h80; settle();
      if (i == 0) begin
        chk("tie first if_gnt L1", 64'(if_gnt[0]), 64'd1);
        chk("tie first if_gnt L3", 64'(if_gnt[1]), 64'd1);
      end
      if (i >= 1 && i <= 3) begin
        chk("L3 ls_gnt held off", 64'(ls_gnt[1]), 64'd0);
        chk("L3 no mem_en in WAIT", 64'(mem_en[1]), 64'd0);
      end
      if (i == 2) begin
        chk("tie ls_gnt with rvalid", 64'(ls_gnt[0]), 64'd1);
        chk("tie if_rvalid", 64'(if_rvalid[0]), 64'd1);
      end
      if (i == 4) begin
        chk("tie if_gnt again L1", 64'(if_gnt[0]), 64'd1);
        chk("L3 ls_gnt at T+4", 64'(ls_gnt[1]), 64'd1);
      end
      adv();
    end
    idle_cycles(6);

    // Load/store request raised and dropped while a fetch is outstanding.
    idle_in(); if_req = 1; settle(); adv();
    idle_in(); ls_req = 1; ls_addr = 32'h300; settle();
    chk("drop ls_gnt L3", 64'(ls_gnt[1]), 64'd0);
    adv();
    idle_in(); settle();
    chk("drop no mem_en L1", 64'(mem_en[0]), 64'd0);
    adv();
    idle_cycles(5);

    // Reset in the middle of outstanding accesses.
    idle_in(); if_req = 1; if_addr = 32'h500; settle(); adv();
    idle_cycles(1);
    idle_in(); rst_n = 1'b0; settle();
    chk("mid-reset if_rvalid L1", 64'(if_rvalid[0]), 64'd0);
    chk("mid-reset mem_en L3", 64'(mem_en[1]), 64'd0);
    adv();
    rst_n = 1'b1;
    idle_cycles(4);
    idle_in(); if_req = 1; if_addr = 32'h600; settle();
    chk("post-reset if_gnt L3", 64'(if_gnt[1]), 64'd1);
    chk("post-reset mem_addr L3", 64'(mem_addr[1]), 64'h600);
    adv();
    idle_cycles(5);

    // Randomised traffic with sticky requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 256) == 0) rst_n = 1'b0;
      else if (!rst_n && ($urandom % 2) == 0) rst_n = 1'b1;
      if (($urandom % 4) != 0) begin
        if_req = ($urandom % 3) != 0;
        if_addr = $urandom;
      end
      if (($urandom % 4) != 0) begin
        ls_req = ($urandom % 2) != 0;
        ls_we = ($urandom % 2) != 0;
        ls_be = BW'($urandom);
        ls_addr = $urandom;
        ls_wdata = $urandom;
      end
      mem_rdata = $urandom;
      settle();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, memory data width in bits; byte-enable width BE_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter MEM_LATENCY, default 1, cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports if_req in 1, if_addr in ADDR_WIDTH: instruction-fetch read request and word address.
REQ-007 Ports if_gnt out 1, if_rvalid out 1, if_rdata out DATA_WIDTH: fetch grant, response strobe, read data.
REQ-008 Ports ls_req in 1, ls_we in 1, ls_be in BE_WIDTH, ls_addr in ADDR_WIDTH, ls_wdata in DATA_WIDTH: load/store request.
REQ-009 Ports ls_gnt out 1, ls_rvalid out 1, ls_rdata out DATA_WIDTH: load/store grant, completion strobe, load data.
REQ-010 Ports mem_en, mem_we out 1; mem_be out BE_WIDTH; mem_addr out ADDR_WIDTH; mem_wdata out DATA_WIDTH; mem_rdata in DATA_WIDTH: single-port memory.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (memory free), WAIT (one transaction outstanding).
REQ-012 In IDLE with exactly one req high, the block SHALL assert that requester's gnt combinationally in the same cycle.
REQ-013 In IDLE with both req high, the block SHALL grant the requester not granted last (round-robin via last_gnt register).
REQ-014 In a grant cycle the block SHALL drive mem_en=1 with mem_addr/mem_we/mem_be/mem_wdata from the granted requester; fetch drives mem_we=0, mem_be all ones, mem_wdata 0.
REQ-015 Outside grant cycles mem_en, mem_we, mem_be, mem_addr, mem_wdata SHALL be 0.
REQ-016 On a grant the FSM SHALL enter WAIT, load a latency counter with MEM_LATENCY, and record the granted owner.
REQ-017 In WAIT both gnt outputs SHALL be 0 regardless of req; ungranted requesters hold req and request fields (arbiter latches nothing un-granted).
REQ-018 The counter SHALL decrement each WAIT cycle; in the cycle it reads 1, mem_rdata is captured on the next edge and FSM returns to IDLE.
REQ-019 With grant in cycle T, the owner's rvalid SHALL be high for exactly cycle T+MEM_LATENCY+1 (registered); the other rvalid stays 0.
REQ-020 For reads, owner's rdata SHALL update to the captured mem_rdata with rvalid; for writes rvalid acknowledges completion and ls_rdata is unchanged.
REQ-021 if_rdata and ls_rdata SHALL hold their last value between responses.
REQ-022 A new grant SHALL be permitted in the same cycle rvalid is high (back-to-back throughput: one transaction per MEM_LATENCY+1 cycles).
REQ-023 A req deasserted before grant SHALL be dropped with no memory access and no rvalid.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, counter=0, all gnt/rvalid/mem_* outputs 0, if_rdata/ls_rdata 0, last_gnt=LS (fetch wins first tie).
REQ-025 Reset during WAIT SHALL abandon the outstanding transaction; no rvalid is produced for it and stale mem_rdata is ignored.
REQ-026 After rst_n rises, first grant SHALL be possible in the first clock cycle with rst_n high.

Verification
REQ-027 MEM_LATENCY=1, if_req only, if_addr=0x100, mem_rdata=0x00500093 at T+1 -> if_gnt/mem_en at T, if_rvalid and if_rdata=0x00500093 at T+2.
REQ-028 if_req and ls_req both high from reset -> fetch granted first, load/store granted in the cycle if_rvalid pulses, then fetch again if still requesting.
REQ-029 ls store, ls_be=0011, ls_wdata=0xDEADBEEF, addr 0x200 -> mem_we=1, mem_be=0011 at T, ls_rvalid at T+2, ls_rdata unchanged.
REQ-030 MEM_LATENCY=3, ls_req asserted during WAIT of a fetch -> ls_gnt stays 0 until cycle T+4, no second mem_en during WAIT.
REQ-031 rst_n pulsed low in WAIT -> all outputs 0 asynchronously, no rvalid afterwards, next request granted normally.
REQ-032 ls_req raised then dropped while fetch in WAIT -> no ls_gnt, no ls_rvalid, FSM idle.
